// File: rtl/mem_req_ctrl.sv
// Data-memory request initiator for the Y86 M stage: decodes the M-stage op,
// issues one valid/ready request, waits for its response and holds the pipeline.
module mem_req_ctrl #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  m_icode,
  input  logic [63:0] m_valA,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valP,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [63:0] dmem_req_addr,
  output logic [63:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rsp_rdata,
  input  logic        dmem_rsp_err,
  output logic [63:0] valM,
  output logic        m_stall,
  output logic        m_done,
  output logic        mem_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              dec_mem;
  logic              dec_we;
  logic [63:0]       dec_addr;
  logic [63:0]       dec_wdata;
  logic              start;
  logic              addr_ok;
  logic              wait_last;

  always_comb begin
    dec_mem   = 1'b0;
    dec_we    = 1'b0;
    dec_addr  = m_valE;
    dec_wdata = m_valA;
    case (m_icode)
      4'h4: begin dec_mem = 1'b1; dec_we = 1'b1; end
      4'h5: begin dec_mem = 1'b1; end
      4'h8: begin dec_mem = 1'b1; dec_we = 1'b1; dec_wdata = m_valP; end
      4'h9: begin dec_mem = 1'b1; dec_addr = m_valA; end
      4'hA: begin dec_mem = 1'b1; dec_we = 1'b1; end
      4'hB: begin dec_mem = 1'b1; dec_addr = m_valA; end
      default: ;
    endcase
  end

  assign start     = m_valid & dec_mem;
  assign addr_ok   = dec_addr < 64'(ADDR_LIMIT);
  // Counter holds the number of completed silent WAIT cycles; this is the last one allowed.
  assign wait_last = cnt_reg == CNT_W'(TIMEOUT - 1);

  assign m_stall = ((state_reg == IDLE) && start) || (state_reg == REQ) || (state_reg == WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      valM           <= '0;
      m_done         <= 1'b0;
      mem_error      <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (addr_ok) begin
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= dec_we;
              dmem_req_addr  <= dec_addr;
              dmem_req_wdata <= dec_wdata;
              state_reg      <= REQ;
            end else begin
              mem_error <= 1'b1;
              m_done    <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            cnt_reg        <= '0;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          // A response in the final allowed cycle still beats the timeout.
          if (dmem_rsp_valid) begin
            if (!dmem_req_we) valM <= dmem_rsp_rdata;
            mem_error <= dmem_rsp_err;
            m_done    <= 1'b1;
            state_reg <= DONE;
          end else if (wait_last) begin
            mem_error <= 1'b1;
            m_done    <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized bench for mem_req_ctrl: a behavioural memory plus a transaction-level
// reference predicts request contents, completion cycle, valM and mem_error.
module tb_mem_req_ctrl;

  localparam int T   = 255;
  localparam int LIM = 1024;
  localparam int BOUND = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  m_icode;
  logic [63:0] m_valA, m_valE, m_valP;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        dmem_rsp_err;
  logic [63:0] valM;
  logic        m_stall, m_done, mem_error;

  int total = 0;
  int passed = 0;
  logic [63:0] valm_model;

  mem_req_ctrl #(.ADDR_LIMIT(LIM), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_icode(m_icode),
    .m_valA(m_valA), .m_valE(m_valE), .m_valP(m_valP),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .dmem_rsp_err(dmem_rsp_err),
    .valM(valM), .m_stall(m_stall), .m_done(m_done), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void ref_decode(input logic [3:0] ic, input logic [63:0] a, e, p,
                                     output bit mem, output bit we,
                                     output logic [63:0] addr, output logic [63:0] data);
    mem  = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    we   = ic inside {4'h4, 4'h8, 4'hA};
    addr = (ic inside {4'h9, 4'hB}) ? a : e;
    data = (ic == 4'h8) ? p : a;
  endfunction

  // One M-stage instruction; the bench plays memory with rdly not-ready cycles and
  // answers in WAIT cycle rspd (beyond T means the memory never answers).
  task automatic run_txn(input logic [3:0] ic, input logic [63:0] a, e, p,
                         input int rdly, input int rspd,
                         input logic [63:0] rdata, input logic rerr);
    bit mem, we, err_path, hs, hs_pend, done_seen, exp_rv, exp_err;
    logic [63:0] addr, data, exp_valm;
    int exp_done, wcnt, seen, w, done_c;
    ref_decode(ic, a, e, p, mem, we, addr, data);
    @(negedge clk);
    m_valid = 1'b1; m_icode = ic; m_valA = a; m_valE = e; m_valP = p;
    if (!mem) begin
      for (int i = 0; i < 2; i++) begin
        #1;
        check("nonmem_stall", 64'(m_stall), 64'd0);
        check("nonmem_req",   64'(dmem_req_valid), 64'd0);
        check("nonmem_done",  64'(m_done), 64'd0);
        @(negedge clk);
      end
      m_valid = 1'b0;
      $display("txn icode=%0h non-memory op, no access", ic);
      return;
    end
    err_path = addr >= 64'(LIM);
    if (err_path) begin
      exp_done = 2; exp_err = 1'b1; exp_valm = valm_model;
    end else begin
      w = (rspd <= T) ? rspd : T;
      exp_done = 3 + rdly + w;
      if (rspd <= T) begin
        exp_err = rerr; exp_valm = we ? valm_model : rdata;
      end else begin
        exp_err = 1'b1; exp_valm = valm_model;
      end
    end
    hs = 0; hs_pend = 0; wcnt = 0; seen = 0; done_seen = 0; done_c = 0;
    for (int c = 1; c <= BOUND && !done_seen; c++) begin
      if (c > 1) begin
        @(negedge clk);
        m_icode = 4'($urandom);
        m_valA = {$urandom, $urandom}; m_valE = {$urandom, $urandom}; m_valP = {$urandom, $urandom};
      end
      dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b0;
      dmem_rsp_rdata = {$urandom, $urandom}; dmem_rsp_err = 1'($urandom);
      if (hs_pend) begin hs = 1; hs_pend = 0; end
      if (hs) wcnt++;
      #1;
      if (m_done) begin
        done_seen = 1; done_c = c;
        check("done_cycle", 64'(c), 64'(exp_done));
        check("mem_error",  64'(mem_error), 64'(exp_err));
        check("valM",       valM, exp_valm);
        check("done_stall", 64'(m_stall), 64'd0);
        valm_model = exp_valm;
      end else begin
        check("stall", 64'(m_stall), 64'd1);
        exp_rv = (c >= 2) && !hs && !hs_pend && !err_path;
        check("req_valid", 64'(dmem_req_valid), 64'(exp_rv));
        if (dmem_req_valid && exp_rv) begin
          check("req_we",    64'(dmem_req_we), 64'(we));
          check("req_addr",  dmem_req_addr, addr);
          check("req_wdata", dmem_req_wdata, we ? data : dmem_req_wdata);
          if (seen == rdly) begin dmem_req_ready = 1'b1; hs_pend = 1; end
          seen++;
        end else if (hs) begin
          dmem_req_ready = 1'($urandom);
        end
        if (hs && wcnt == rspd) begin
          dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata; dmem_rsp_err = rerr;
        end
      end
    end
    check("done_seen", 64'(done_seen), 64'd1);
    m_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    @(negedge clk); #1;
    check("post_done", 64'(m_done), 64'd0);
    $display("txn icode=%0h addr=0x%0h we=%0d done_cycle=%0d err=%0d valM=0x%0h",
             ic, addr, we, done_c, mem_error, valM);
  endtask

  logic [3:0] ic_tab [8] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h6};

  function automatic logic [63:0] rand_addr();
    int mode;
    mode = $urandom_range(0, 9);
    case (mode)
      0: return 64'(LIM);
      1: return 64'(LIM - 1);
      2: return {$urandom, $urandom} | 64'h1_0000_0000;
      default: return 64'($urandom_range(0, LIM - 1));
    endcase
  endfunction

  initial begin
    int rsel, rspd;
    reset = 1'b1; m_valid = 1'b0; m_icode = '0;
    m_valA = '0; m_valE = '0; m_valP = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0; dmem_rsp_err = 1'b0;
    valm_model = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    check("rst_we",        64'(dmem_req_we), 64'd0);
    check("rst_addr",      dmem_req_addr, 64'd0);
    check("rst_wdata",     dmem_req_wdata, 64'd0);
    check("rst_valM",      valM, 64'd0);
    check("rst_done",      64'(m_done), 64'd0);
    check("rst_err",       64'(mem_error), 64'd0);
    check("rst_stall",     64'(m_stall), 64'd0);

    run_txn(4'h5, 64'h0, 64'h10, 64'h0, 0, 1, 64'hDEADBEEF, 1'b0);
    run_txn(4'h8, 64'h0, 64'h3F8, 64'h123, 3, 2, 64'hAAAA, 1'b0);
    run_txn(4'hB, 64'h400, 64'h0, 64'h0, 0, 1, 64'h1, 1'b0);
    run_txn(4'h9, 64'h20, 64'h0, 64'h0, 0, T + 5, 64'h2, 1'b0);
    run_txn(4'h5, 64'h0, 64'h30, 64'h0, 0, T, 64'h55, 1'b0);

    // Reset while waiting for a response, then a stale response arrives in IDLE.
    @(negedge clk);
    m_valid = 1'b1; m_icode = 4'h5; m_valE = 64'h10; m_valA = '0; dmem_req_ready = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_req", 64'(dmem_req_valid), 64'd1);
    @(negedge clk);
    dmem_req_ready = 1'b0; m_valid = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_drop", 64'(dmem_req_valid), 64'd0);
    check("rst_mid_stall", 64'(m_stall), 64'd0);
    reset = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'hBAD0BAD0;
    @(negedge clk);
    dmem_rsp_valid = 1'b0; #1;
    check("stale_valM", valM, 64'd0);
    check("stale_done", 64'(m_done), 64'd0);
    check("stale_req",  64'(dmem_req_valid), 64'd0);
    valm_model = '0;
    run_txn(4'hA, 64'h777, 64'h8, 64'h0, 1, 2, 64'h3, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rsel = $urandom_range(0, 19);
      if (rsel == 0) rspd = T;
      else if (rsel == 1) rspd = T + 1 + $urandom_range(0, 2);
      else rspd = $urandom_range(1, 6);
      run_txn(ic_tab[$urandom_range(0, 7)], rand_addr(), rand_addr(), {$urandom, $urandom},
              $urandom_range(0, 4), rspd, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
